// File: rtl/debug_mem_ctrl_if.sv
// Bus bundle between the debug controller, the SPI slave and the shared RAM port.
interface debug_mem_ctrl_if #(
    parameter int NB_BITS = 32,
    parameter int NB_ADDR = 10
);
    logic [NB_BITS-1:0] i_cmd;
    logic               i_cmd_valid;
    logic [NB_BITS-1:0] o_spi_data;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_BITS-1:0] o_mem_data;
    logic               o_mem_we;
    logic [NB_BITS-1:0] i_mem_data;
    logic               o_cpu_halt;
    logic               o_busy;

    // Controller side
    modport slave (
        input  i_cmd, i_cmd_valid, i_mem_data,
        output o_spi_data, o_mem_addr, o_mem_data, o_mem_we, o_cpu_halt, o_busy
    );

    // SPI slave / RAM side driving the controller
    modport master (
        output i_cmd, i_cmd_valid, i_mem_data,
        input  o_spi_data, o_mem_addr, o_mem_data, o_mem_we, o_cpu_halt, o_busy
    );
endinterface

// File: rtl/debug_mem_ctrl.sv
// Debug memory controller: decodes SPI command words, assembles write data,
// sequences RAM writes/reads with address auto-increment and owns CPU halt.
module debug_mem_ctrl #(
    parameter int NB_BITS    = 32,
    parameter int NB_ADDR    = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    debug_mem_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CAP
    } state_t;

    typedef enum logic [1:0] {
        LD_NONE = 2'b00,
        LD_HL   = 2'b01,
        LD_HU   = 2'b10,
        LD_ADDR = 2'b11
    } load_t;

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_BITS-1:0] wdata_q, wdata_d;
    logic [NB_ADDR-1:0] last_addr_q, last_addr_d;
    logic [NB_BITS-1:0] rdata_q, rdata_d;
    logic [15:0]        wr_count_q, wr_count_d;
    logic               err_halt_q, err_halt_d;
    logic               err_busy_q, err_busy_d;
    logic               halt_q, halt_d;
    logic [1:0]         sel_q, sel_d;
    logic [2:0]         lat_cnt_q, lat_cnt_d;

    logic        cmd_wr;
    logic        cmd_rd;
    load_t       cmd_load;
    logic        cmd_halt;
    logic [1:0]  cmd_sel;
    logic [15:0] cmd_payload;
    logic        busy;

    assign cmd_wr      = bus.i_cmd[31];
    assign cmd_rd      = bus.i_cmd[30];
    assign cmd_load    = load_t'(bus.i_cmd[29:28]);
    assign cmd_halt    = bus.i_cmd[27];
    assign cmd_sel     = bus.i_cmd[26:25];
    assign cmd_payload = bus.i_cmd[15:0];
    assign busy        = (state_q != ST_IDLE);

    // State register and all controller registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_addr_q <= '0;
            rdata_q     <= '0;
            wr_count_q  <= '0;
            err_halt_q  <= 1'b0;
            err_busy_q  <= 1'b0;
            halt_q      <= 1'b0;
            sel_q       <= '0;
            lat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            last_addr_q <= last_addr_d;
            rdata_q     <= rdata_d;
            wr_count_q  <= wr_count_d;
            err_halt_q  <= err_halt_d;
            err_busy_q  <= err_busy_d;
            halt_q      <= halt_d;
            sel_q       <= sel_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

    // Command decode, register updates and next-state sequencing
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        last_addr_d = last_addr_q;
        rdata_d     = rdata_q;
        wr_count_d  = wr_count_q;
        err_halt_d  = err_halt_q;
        err_busy_d  = err_busy_q;
        halt_d      = halt_q;
        sel_d       = sel_q;
        lat_cnt_d   = lat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_cmd_valid) begin
                    case (cmd_load)
                        LD_HL:   wdata_d[15:0]  = cmd_payload;
                        LD_HU:   wdata_d[31:16] = cmd_payload;
                        LD_ADDR: begin
                            addr_d     = cmd_payload[NB_ADDR-1:0];
                            wr_count_d = '0;
                            err_halt_d = 1'b0;
                            err_busy_d = 1'b0;
                        end
                        default: ;
                    endcase
                    sel_d  = cmd_sel;
                    halt_d = cmd_halt;
                    // Error flag is applied after an ADDR clear in the same word
                    if (cmd_wr || cmd_rd) begin
                        if (!cmd_halt) begin
                            err_halt_d = 1'b1;
                        end else if (cmd_wr) begin
                            state_d = ST_WR;
                        end else begin
                            state_d   = ST_RD;
                            lat_cnt_d = '0;
                        end
                    end
                end
            end
            ST_WR: begin
                last_addr_d = addr_q;
                addr_d      = addr_q + 1'b1;
                if (wr_count_q != 16'hFFFF) begin
                    wr_count_d = wr_count_q + 16'd1;
                end
                state_d = ST_IDLE;
            end
            ST_RD: begin
                if (lat_cnt_q == 3'(RD_LATENCY - 1)) begin
                    state_d = ST_CAP;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            ST_CAP: begin
                rdata_d     = bus.i_mem_data;
                last_addr_d = addr_q;
                addr_d      = addr_q + 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.i_cmd_valid && busy) begin
            err_busy_d = 1'b1;
        end
    end

    // RAM port and SPI readback word
    always_comb begin
        bus.o_mem_addr = addr_q;
        bus.o_mem_data = wdata_q;
        bus.o_mem_we   = (state_q == ST_WR);
        bus.o_cpu_halt = halt_q;
        bus.o_busy     = busy;
        case (sel_q)
            2'b00:   bus.o_spi_data = NB_BITS'(addr_q);
            2'b01:   bus.o_spi_data = NB_BITS'(last_addr_q);
            2'b10:   bus.o_spi_data = rdata_q;
            default: bus.o_spi_data = NB_BITS'({err_busy_q, err_halt_q, busy, halt_q,
                                                12'b0, wr_count_q});
        endcase
    end

endmodule

// File: doc/debug_mem_ctrl.md
# debug_mem_ctrl

Debug-unit controller between the parallel SPI slave and the instruction/data single-port RAM. It decodes each 32-bit command word delivered by the SPI slave and assembles write data from two half-word loads. It sequences single-cycle RAM writes and latency-aware RAM reads with address auto-increment, and halts the CPU so the RAM port can be handed to the debug path. It also drives the word returned to the SPI master (address, last address, read data or status).

## Interface
- NB_BITS, 32, command/data word width
- NB_ADDR, 10, RAM address width
- RD_LATENCY, 1, RAM read latency in clocks (legal 1..7)

- i_clk  input  1  system clock, all state on rising edge
- i_rst  input  1  asynchronous, active-low reset
- i_cmd  input  NB_BITS  command word from SPI slave
- i_cmd_valid  input  1  one-cycle strobe: i_cmd holds a new word
- o_spi_data  output  NB_BITS  word loaded into SPI slave for next transfer
- o_mem_addr  output  NB_ADDR  RAM address
- o_mem_data  output  NB_BITS  RAM write data
- o_mem_we  output  1  RAM write enable
- i_mem_data  input  NB_BITS  RAM read data
- o_cpu_halt  output  1  CPU halted; also RAM port mux select (1 = debug owns RAM)
- o_busy  output  1  controller not in IDLE

## Operation
- Command fields: [31] write, [30] read, [29:28] load (00 none, 01 HL, 10 HU, 11 ADDR), [27] halt, [26:25] readback select, [15:0] payload.
- Registers: addr (NB_ADDR), wdata (NB_BITS), last_addr (NB_ADDR), rdata (NB_BITS), wr_count (16), err_halt, err_busy, halt. All reset to 0.
- Accept: i_cmd_valid=1 and state IDLE. On the accept edge:
  - Load: HL → wdata[15:0], HU → wdata[31:16], ADDR → addr=payload[NB_ADDR-1:0]. ADDR also clears wr_count, err_halt and err_busy.
  - Readback select is registered.
  - halt <= [27].
- Operation uses the post-load registers. It is legal only if [27]=1 in the same word. If [31] or [30] is set with [27]=0: no access, err_halt set, stay IDLE.
- [31] and [30] both set: the write executes, the read is ignored, and err_halt is not set.
- i_cmd_valid while busy: the word is dropped entirely (no load, no halt change), and err_busy is set.
- States:
  - IDLE: wait for accept. Go to WR if a legal write, RD if a legal read, otherwise stay.
  - WR, 1 cycle: o_mem_we=1, o_mem_addr=addr, o_mem_data=wdata. On exit: last_addr<=addr, addr<=addr+1, wr_count<=wr_count+1. Next state IDLE.
  - RD, RD_LATENCY cycles (3-bit counter): o_mem_addr=addr. Next state CAP.
  - CAP, 1 cycle: rdata<=i_mem_data, last_addr<=addr, addr<=addr+1. Next state IDLE.
- Arithmetic:
  - addr wraps modulo 2^NB_ADDR (max → 0).
  - wr_count saturates at 16'hFFFF.
- o_spi_data, combinational from registered select:
  - 00: addr, zero-extended
  - 01: last_addr, zero-extended
  - 10: rdata
  - 11: {err_busy, err_halt, o_busy, halt, 12'b0, wr_count}
- In IDLE, o_mem_addr=addr, o_mem_we=0, o_mem_data=wdata.

## Timing
- Reset, applied any time (including mid-operation), forces IDLE immediately. All registers go to 0, so o_mem_we=0, o_cpu_halt=0, o_busy=0, o_spi_data=0. No partial write completes.
- Write: accept at edge E0. WR during cycle E0→E1, with o_mem_we high exactly one cycle. o_busy is high for 1 cycle. The next command is accepted at E1.
- Read: accept at E0. RD spans RD_LATENCY cycles, then CAP for 1 cycle. o_busy is high for RD_LATENCY+1 cycles. rdata is valid from edge E0+RD_LATENCY+1.
- o_cpu_halt changes on the accept edge. Ownership of the RAM switches in the same cycle that WR/RD begins.
- Back-to-back strobes are accepted only in IDLE; there is no buffering.

## Test plan
- Reset mid-read (RD_LATENCY=3, assert i_rst in the 2nd RD cycle) → o_busy=0 and o_spi_data=0 immediately. After release, state is IDLE and all registers are 0.
- Load sequence HL=FFFF, HU=F0F0, ADDR=0x004 (each with [27]=1), then write → one o_mem_we pulse at address 0x004 with data 0xF0F0FFFF. Afterwards addr=0x005, last_addr=0x004, and select 00 returns 0x00000005.
- Preload RAM[0x010]=0xDEADBEEF, send ADDR=0x010 with [30]=1, [27]=1, select 10 → o_busy high for RD_LATENCY+1 cycles. After that, o_spi_data=0xDEADBEEF and addr=0x011.
- Write with [27]=0 → no o_mem_we. Status word has bit30=1 and wr_count=0. A subsequent ADDR load clears bit30.
- Strobe during WR/RD → word dropped, status bit31=1, and addr/wdata/halt are unchanged.
- ADDR=0x3FF then two writes → the writes go to 0x3FF and then 0x000, addr=0x001, and wr_count=2.
